// File: rtl/branch_resolve.sv
// ---------------------------------------------------------------------------
// branch_resolve
// Resolves conditional branches, JAL and JALR from the operand comparator
// results, computes the redirect target and the pc+4 link value, and holds
// the result in a one-entry output register with a valid/ready handshake.
// The front end predicts not-taken, so every taken branch or jump redirects.
//
// Optional feature macro: BRANCH_STAT_EN
//   defined   : resolved-branch and taken-branch counters are instantiated.
//   undefined : stat_br_cnt and stat_tk_cnt are tied to zero.
// ---------------------------------------------------------------------------
module branch_resolve #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [2:0]      in_funct3,
    input  logic            in_is_br,
    input  logic            in_is_jal,
    input  logic            in_is_jalr,
    input  logic            cmp_eq,
    input  logic            cmp_neq,
    input  logic            cmp_slt,
    input  logic            cmp_snlt,
    input  logic            cmp_uslt,
    input  logic            cmp_usnlt,
    output logic            res_valid,
    input  logic            res_ready,
    output logic            res_taken,
    output logic [XLEN-1:0] res_target,
    output logic [XLEN-1:0] res_link,
    output logic            res_misalign,
    output logic            res_illegal,
    output logic [XLEN-1:0] stat_br_cnt,
    output logic [XLEN-1:0] stat_tk_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          state_r;
    logic            accept_s;
    logic [XLEN-1:0] pc_imm_s;
    logic [XLEN-1:0] jalr_sum_s;
    logic [XLEN-1:0] link_s;
    logic [XLEN-1:0] target_s;
    logic            cond_s;
    logic            br_bad_s;
    logic            taken_s;
    logic            illegal_s;
    logic            misalign_s;

    // Mask that clears bit 0 of the JALR sum.
    localparam logic [XLEN-1:0] JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};

    assign res_valid  = (state_r == FULL);
    // A new beat may enter whenever the held result leaves in the same cycle.
    assign in_ready   = !res_valid || res_ready;
    assign accept_s   = in_valid && in_ready && !flush;

    // All address arithmetic wraps silently modulo 2^XLEN.
    assign pc_imm_s   = in_pc + in_imm;
    assign jalr_sum_s = in_rs1 + in_imm;
    assign link_s     = in_pc + XLEN'(4);

    // funct3 010/011 are not branch encodings; they resolve as illegal, not taken.
    assign br_bad_s   = (in_funct3 == 3'b010) || (in_funct3 == 3'b011);

    // Select the comparator bit that decides the conditional branch.
    always_comb begin
        cond_s = 1'b0;
        case (in_funct3)
            3'b000:  cond_s = cmp_eq;
            3'b001:  cond_s = cmp_neq;
            3'b100:  cond_s = cmp_slt;
            3'b101:  cond_s = cmp_snlt;
            3'b110:  cond_s = cmp_uslt;
            3'b111:  cond_s = cmp_usnlt;
            default: cond_s = 1'b0;
        endcase
    end

    // Resolve taken/target/illegal with priority jalr > jal > br.
    always_comb begin
        taken_s   = 1'b0;
        target_s  = link_s;
        illegal_s = 1'b0;
        if (in_is_jalr) begin
            taken_s   = 1'b1;
            target_s  = jalr_sum_s & JALR_MASK;
            illegal_s = 1'b0;
        end else if (in_is_jal) begin
            taken_s   = 1'b1;
            target_s  = pc_imm_s;
            illegal_s = 1'b0;
        end else if (in_is_br) begin
            taken_s   = cond_s && !br_bad_s;
            target_s  = pc_imm_s;
            illegal_s = br_bad_s;
        end else begin
            taken_s   = 1'b0;
            target_s  = link_s;
            illegal_s = 1'b0;
        end
    end

    // Misalignment only matters when the redirect is actually taken.
    assign misalign_s = taken_s && (target_s[1:0] != 2'b00);

    // Output register FSM: flush beats both accept and hold; stall keeps res_* stable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= EMPTY;
            res_taken    <= 1'b0;
            res_target   <= RESET_PC;
            res_link     <= {XLEN{1'b0}};
            res_misalign <= 1'b0;
            res_illegal  <= 1'b0;
        end else if (flush) begin
            state_r      <= EMPTY;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (accept_s) begin
                        state_r <= FULL;
                    end else begin
                        state_r <= EMPTY;
                    end
                end
                FULL: begin
                    if (accept_s) begin
                        state_r <= FULL;
                    end else if (res_ready) begin
                        state_r <= EMPTY;
                    end else begin
                        state_r <= FULL;
                    end
                end
                default: state_r <= EMPTY;
            endcase
            if (accept_s) begin
                res_taken    <= taken_s;
                res_target   <= target_s;
                res_link     <= link_s;
                res_misalign <= misalign_s;
                res_illegal  <= illegal_s;
            end
        end
    end

`ifdef BRANCH_STAT_EN
    logic [XLEN-1:0] br_cnt_r;
    logic [XLEN-1:0] tk_cnt_r;

    // Count accepted branches and accepted taken branches; flushed beats never count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            br_cnt_r <= {XLEN{1'b0}};
            tk_cnt_r <= {XLEN{1'b0}};
        end else if (accept_s && in_is_br) begin
            br_cnt_r <= br_cnt_r + XLEN'(1);
            if (taken_s) begin
                tk_cnt_r <= tk_cnt_r + XLEN'(1);
            end
        end
    end

    assign stat_br_cnt = br_cnt_r;
    assign stat_tk_cnt = tk_cnt_r;
`else
    assign stat_br_cnt = {XLEN{1'b0}};
    assign stat_tk_cnt = {XLEN{1'b0}};
`endif

endmodule
